// File: rtl/vin_pkg.sv
// Shared types and defaults for the frame-synchronous video source selector.
package vin_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_OUT = 2'd1,
    WAIT_IN  = 2'd2
  } vin_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Roughly two frames at 81 MHz before a wait state gives up.
  localparam int VIN_TO_W_DEF    = 24;
  localparam int VIN_TIMEOUT_DEF = 2700000;

endpackage

// File: rtl/vin_vs_mon.sv
// Per-source vsync monitor: rising-edge detect, plus a loss watchdog when
// VIN_SEL_LOS_EN is defined (otherwise lost is tied low).
module vin_vs_mon
`ifdef VIN_SEL_LOS_EN
  #(
    parameter int TO_W    = vin_pkg::VIN_TO_W_DEF,
    parameter int TIMEOUT = vin_pkg::VIN_TIMEOUT_DEF
  )
`endif
  (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic rise,
    output logic lost
  );

  logic vs_prev;
  logic armed;

  // armed masks the first cycle after reset so a vsync already high is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vs_prev <= vsync;
      armed   <= 1'b1;
    end
  end

  assign rise = armed & vsync & ~vs_prev;

`ifdef VIN_SEL_LOS_EN
  localparam logic [TO_W-1:0] WD_MAX = TO_W'(TIMEOUT);

  logic [TO_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (rise) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign lost = (wd_cnt == WD_MAX);
`else
  assign lost = 1'b0;
`endif

endmodule

// File: rtl/vin_source_sel.sv
// Frame-synchronous 2:1 video source selector; switches only on vsync rising
// edges and blanks between frames. VIN_SEL_LOS_EN adds per-source loss blanking.
module vin_source_sel
  import vin_pkg::*;
#(
  parameter int PIXW        = 8,
  parameter int TO_W        = VIN_TO_W_DEF,
  parameter int TIMEOUT     = VIN_TIMEOUT_DEF,
  parameter bit DEFAULT_SRC = SRC_A
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel_req,
  input  logic            a_vsync,
  input  logic            a_hsync,
  input  logic            a_de,
  input  logic [PIXW-1:0] a_pixel,
  input  logic            b_vsync,
  input  logic            b_hsync,
  input  logic            b_de,
  input  logic [PIXW-1:0] b_pixel,
  output logic            v_vsync,
  output logic            v_hsync,
  output logic            v_de,
  output logic [PIXW-1:0] v_pixel,
  output logic            active_src,
  output logic            switching,
  output logic            to_pulse,
  output logic [1:0]      src_lost
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  vin_state_e      state_q, state_nxt;
  logic            active_q, active_nxt;
  logic [TO_W-1:0] cnt_q;

  logic rise_a, rise_b, lost_a, lost_b;
  logic rise_act, rise_new, to_last;

  logic            act_vs, act_hs, act_de;
  logic [PIXW-1:0] act_px;
  logic            new_vs, new_hs, new_de;
  logic [PIXW-1:0] new_px;

  logic            vs_d, hs_d, de_d, to_d;
  logic [PIXW-1:0] px_d;

  vin_vs_mon
`ifdef VIN_SEL_LOS_EN
    #(.TO_W(TO_W), .TIMEOUT(TIMEOUT))
`endif
    u_mon_a (
      .clk  (clk),
      .rst  (rst),
      .vsync(a_vsync),
      .rise (rise_a),
      .lost (lost_a)
    );

  vin_vs_mon
`ifdef VIN_SEL_LOS_EN
    #(.TO_W(TO_W), .TIMEOUT(TIMEOUT))
`endif
    u_mon_b (
      .clk  (clk),
      .rst  (rst),
      .vsync(b_vsync),
      .rise (rise_b),
      .lost (lost_b)
    );

  // "act" is the source currently on air, "new" is the other one.
  always_comb begin
    if (active_q == SRC_B) begin
      act_vs = b_vsync; act_hs = b_hsync; act_de = b_de; act_px = b_pixel;
      new_vs = a_vsync; new_hs = a_hsync; new_de = a_de; new_px = a_pixel;
      rise_act = rise_b;
      rise_new = rise_a;
    end else begin
      act_vs = a_vsync; act_hs = a_hsync; act_de = a_de; act_px = a_pixel;
      new_vs = b_vsync; new_hs = b_hsync; new_de = b_de; new_px = b_pixel;
      rise_act = rise_a;
      rise_new = rise_b;
    end
  end

  assign to_last = (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      active_q <= DEFAULT_SRC;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_nxt;
      active_q <= active_nxt;
      if (state_nxt != state_q) begin
        cnt_q <= '0;
      end else if (state_q != RUN) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state_q;
    active_nxt = active_q;
    case (state_q)
      RUN: begin
        if (sel_req != active_q) state_nxt = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (sel_req == active_q) begin
          state_nxt = RUN;
        end else if (rise_act && rise_new) begin
          state_nxt  = RUN;
          active_nxt = ~active_q;
        end else if (rise_act || to_last) begin
          state_nxt = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (rise_new || to_last) begin
          state_nxt  = RUN;
          active_nxt = ~active_q;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    vs_d = act_vs;
    hs_d = act_hs;
    de_d = act_de;
    px_d = act_px;
    to_d = 1'b0;
    case (state_q)
      RUN: begin
`ifdef VIN_SEL_LOS_EN
        // A lost source stays blanked until its next vsync rise, which is kept.
        if ((active_q == SRC_B ? lost_b : lost_a) && !rise_act) begin
          vs_d = 1'b0; hs_d = 1'b0; de_d = 1'b0; px_d = '0;
        end
`endif
      end
      WAIT_OUT: begin
        if (sel_req == active_q) begin
          to_d = 1'b0;
        end else if (rise_act && rise_new) begin
          vs_d = new_vs; hs_d = new_hs; de_d = new_de; px_d = new_px;
        end else if (rise_act || to_last) begin
          vs_d = 1'b0; hs_d = 1'b0; de_d = 1'b0; px_d = '0;
          to_d = ~rise_act;
        end
      end
      WAIT_IN: begin
        if (rise_new) begin
          vs_d = new_vs; hs_d = new_hs; de_d = new_de; px_d = new_px;
        end else begin
          vs_d = 1'b0; hs_d = 1'b0; de_d = 1'b0; px_d = '0;
          to_d = to_last;
        end
      end
      default: begin
        vs_d = 1'b0; hs_d = 1'b0; de_d = 1'b0; px_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_vsync  <= 1'b0;
      v_hsync  <= 1'b0;
      v_de     <= 1'b0;
      v_pixel  <= '0;
      to_pulse <= 1'b0;
    end else begin
      v_vsync  <= vs_d;
      v_hsync  <= hs_d;
      v_de     <= de_d;
      v_pixel  <= px_d;
      to_pulse <= to_d;
    end
  end

  assign active_src = active_q;
  assign switching  = (state_q != RUN);
  assign src_lost   = {lost_b, lost_a};

endmodule

// File: tb/tb_vin_source_sel.sv
// Scoreboard bench for vin_source_sel: driver pushes hand-derived expectations,
// a monitor pops and compares one entry per output cycle.
module tb_vin_source_sel;

  localparam int PIXW = 8;
  localparam int TO   = 200;

  localparam logic [1:0] M_A  = 2'd0;
  localparam logic [1:0] M_B  = 2'd1;
  localparam logic [1:0] M_BL = 2'd2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sel_req = 1'b0;
  logic            a_vsync = 1'b0, a_hsync = 1'b0, a_de = 1'b0;
  logic [PIXW-1:0] a_pixel = '0;
  logic            b_vsync = 1'b0, b_hsync = 1'b0, b_de = 1'b0;
  logic [PIXW-1:0] b_pixel = '0;
  logic            v_vsync, v_hsync, v_de;
  logic [PIXW-1:0] v_pixel;
  logic            active_src, switching, to_pulse;
  logic [1:0]      src_lost;

  always #5 clk = ~clk;

  vin_source_sel #(
    .PIXW(PIXW), .TO_W(24), .TIMEOUT(TO), .DEFAULT_SRC(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .sel_req(sel_req),
    .a_vsync(a_vsync), .a_hsync(a_hsync), .a_de(a_de), .a_pixel(a_pixel),
    .b_vsync(b_vsync), .b_hsync(b_hsync), .b_de(b_de), .b_pixel(b_pixel),
    .v_vsync(v_vsync), .v_hsync(v_hsync), .v_de(v_de), .v_pixel(v_pixel),
    .active_src(active_src), .switching(switching), .to_pulse(to_pulse),
    .src_lost(src_lost)
  );

  typedef struct {
    logic            vs, hs, de;
    logic [PIXW-1:0] px;
    logic            act, sw, to;
    logic [1:0]      lost;
    string           tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s.%s got=%0h expected=%0h t=%0t", tag, nm, got, want, $time);
    end
  endtask

  // One input cycle; expectation describes the outputs after the next posedge.
  task automatic cyc(input string tag, input logic r, input logic s, input logic av, input logic bv,
                     input logic [1:0] m, input logic act, input logic sw, input logic to,
                     input logic [1:0] lost);
    exp_t e;
    @(negedge clk);
    rst     = r;
    sel_req = s;
    a_vsync = av;
    a_hsync = 1'($urandom);
    a_de    = 1'($urandom);
    a_pixel = PIXW'($urandom);
    b_vsync = bv;
    b_hsync = 1'($urandom);
    b_de    = 1'($urandom);
    b_pixel = PIXW'($urandom);
    case (m)
      M_A:     begin e.vs = av; e.hs = a_hsync; e.de = a_de; e.px = a_pixel; end
      M_B:     begin e.vs = bv; e.hs = b_hsync; e.de = b_de; e.px = b_pixel; end
      default: begin e.vs = 1'b0; e.hs = 1'b0; e.de = 1'b0; e.px = '0; end
    endcase
    e.act  = act;
    e.sw   = sw;
    e.to   = to;
    e.lost = lost;
    e.tag  = tag;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.tag, "v_vsync",    32'(v_vsync),    32'(e.vs));
        chk(e.tag, "v_hsync",    32'(v_hsync),    32'(e.hs));
        chk(e.tag, "v_de",       32'(v_de),       32'(e.de));
        chk(e.tag, "v_pixel",    32'(v_pixel),    32'(e.px));
        chk(e.tag, "active_src", 32'(active_src), 32'(e.act));
        chk(e.tag, "switching",  32'(switching),  32'(e.sw));
        chk(e.tag, "to_pulse",   32'(to_pulse),   32'(e.to));
        chk(e.tag, "src_lost",   32'(src_lost),   32'(e.lost));
      end
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit");
  end

  initial begin : stim
    repeat (3) cyc("reset", 1, 0, 0, 0, M_BL, 0, 0, 0, 2'b00);
`ifdef VIN_SEL_LOS_EN
    for (int n = 1; n <= 210; n++)
      cyc("los_run", 0, 0, logic'(n == 2), logic'(n % 50 == 0),
          (n >= 203) ? M_BL : M_A, 0, 0, 0, (n >= 202) ? 2'b01 : 2'b00);
    cyc("los_resume", 0, 0, 1, 0, M_A, 0, 0, 0, 2'b00);
    repeat (3) cyc("los_after", 0, 0, 0, 0, M_A, 0, 0, 0, 2'b00);
`else
    repeat (5) cyc("pass_a", 0, 0, 0, 0, M_A, 0, 0, 0, 2'b00);

    cyc("sw_req", 0, 1, 0, 0, M_A, 0, 1, 0, 2'b00);
    repeat (10) cyc("sw_wait_out", 0, 1, 0, 0, M_A, 0, 1, 0, 2'b00);
    cyc("sw_a_rise", 0, 1, 1, 0, M_BL, 0, 1, 0, 2'b00);
    repeat (20) cyc("sw_wait_in", 0, 1, 1, 0, M_BL, 0, 1, 0, 2'b00);
    cyc("sw_b_rise", 0, 1, 0, 1, M_B, 1, 0, 0, 2'b00);
    repeat (3) cyc("sw_b_hi", 0, 1, 0, 1, M_B, 1, 0, 0, 2'b00);
    repeat (5) cyc("sw_b_run", 0, 1, 0, 0, M_B, 1, 0, 0, 2'b00);

    cyc("cancel_req", 0, 0, 0, 0, M_B, 1, 1, 0, 2'b00);
    cyc("cancel_back", 0, 1, 0, 1, M_B, 1, 0, 0, 2'b00);
    repeat (3) cyc("cancel_run", 0, 1, 0, 0, M_B, 1, 0, 0, 2'b00);

    cyc("sim_req", 0, 0, 0, 0, M_B, 1, 1, 0, 2'b00);
    repeat (3) cyc("sim_wait_out", 0, 0, 0, 0, M_B, 1, 1, 0, 2'b00);
    cyc("sim_rise", 0, 0, 1, 1, M_A, 0, 0, 0, 2'b00);
    repeat (2) cyc("sim_hi", 0, 0, 1, 1, M_A, 0, 0, 0, 2'b00);
    repeat (3) cyc("sim_run", 0, 0, 0, 0, M_A, 0, 0, 0, 2'b00);

    cyc("toin_req", 0, 1, 0, 0, M_A, 0, 1, 0, 2'b00);
    repeat (2) cyc("toin_wait_out", 0, 1, 0, 0, M_A, 0, 1, 0, 2'b00);
    cyc("toin_a_rise", 0, 1, 1, 0, M_BL, 0, 1, 0, 2'b00);
    repeat (TO - 1) cyc("toin_wait_in", 0, 1, 0, 0, M_BL, 0, 1, 0, 2'b00);
    cyc("toin_expire", 0, 1, 0, 0, M_BL, 1, 0, 1, 2'b00);
    repeat (3) cyc("toin_raw_b", 0, 1, 0, 0, M_B, 1, 0, 0, 2'b00);

    cyc("toout_req", 0, 0, 0, 0, M_B, 1, 1, 0, 2'b00);
    repeat (TO - 1) cyc("toout_wait_out", 0, 0, 0, 0, M_B, 1, 1, 0, 2'b00);
    cyc("toout_expire", 0, 0, 0, 0, M_BL, 1, 1, 1, 2'b00);
    repeat (5) cyc("toout_wait_in", 0, 0, 0, 0, M_BL, 1, 1, 0, 2'b00);
    cyc("toout_a_rise", 0, 0, 1, 0, M_A, 0, 0, 0, 2'b00);
    repeat (2) cyc("toout_run", 0, 0, 0, 0, M_A, 0, 0, 0, 2'b00);

    cyc("rst_req", 0, 1, 0, 0, M_A, 0, 1, 0, 2'b00);
    cyc("rst_a_rise", 0, 1, 1, 0, M_BL, 0, 1, 0, 2'b00);
    repeat (2) cyc("rst_wait_in", 0, 1, 1, 0, M_BL, 0, 1, 0, 2'b00);
    repeat (2) cyc("rst_mid", 1, 1, 1, 0, M_BL, 0, 0, 0, 2'b00);
    cyc("rst_rerun", 0, 1, 1, 0, M_A, 0, 1, 0, 2'b00);
    cyc("rst_vs_held", 0, 1, 1, 0, M_A, 0, 1, 0, 2'b00);
    cyc("rst_vs_low", 0, 1, 0, 0, M_A, 0, 1, 0, 2'b00);
    cyc("rst_a_rise2", 0, 1, 1, 0, M_BL, 0, 1, 0, 2'b00);
    cyc("rst_b_rise", 0, 1, 0, 1, M_B, 1, 0, 0, 2'b00);
    cyc("rst_on_b", 1, 1, 0, 0, M_BL, 0, 0, 0, 2'b00);
    cyc("rst_pending", 0, 1, 0, 0, M_A, 0, 1, 0, 2'b00);
    repeat (2) cyc("rst_pending_wait", 0, 1, 0, 0, M_A, 0, 1, 0, 2'b00);
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: entries_left=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vin_source_sel.md
Name: vin_source_sel

Overview:
- Frame-synchronous 2:1 video source selector/scheduler between video producers (internal test-pattern generator, external video input) and the downstream EPD datapath.
- Switches only on frame boundaries (source vsync rising edge) and blanks output between the end of the old frame and the start of the new one. Downstream controllers never see a torn frame.
- Timeout watchdog on each wait state; a dead source cannot deadlock a switch.

Parameters:
- PIXW, 8, pixel bus width (2 pixels/clk Y4).
- TO_W, 24, width of wait-timeout counter.
- TIMEOUT, 2700000, cycles allowed in a wait state (~2 frames at 81 MHz); benches override to 200.
- DEFAULT_SRC, 0, source selected after reset.

Ports:
- clk  in  1  pixel clock; both sources and output share it.
- rst  in  1  synchronous, active-high reset.
- sel_req  in  1  requested source (0 = A, 1 = B), level.
- a_vsync, a_hsync, a_de  in  1 each  source A timing, active high.
- a_pixel  in  PIXW  source A pixels.
- b_vsync, b_hsync, b_de  in  1 each  source B timing, active high.
- b_pixel  in  PIXW  source B pixels.
- v_vsync, v_hsync, v_de  out  1 each  selected timing, registered.
- v_pixel  out  PIXW  selected pixels, registered.
- active_src  out  1  source currently driving output.
- switching  out  1  high in WAIT_OUT/WAIT_IN.
- to_pulse  out  1  one-cycle pulse on any wait timeout.
- src_lost  out  2  [0] = A lost, [1] = B lost (see optional feature).

Behaviour:
- Reset state: RUN, active_src = DEFAULT_SRC, all v_* = 0, to_pulse = 0, src_lost = 0, vs_prev = 0, counter = 0.
- Edge detection: rise_x = x_vsync & ~x_vsync_prev, with prev registered per source. A source whose vsync is already high at reset gives no rise.
- Latency: input to v_* is exactly 1 cycle when passing. "Blank" loads all v_* = 0.
- RUN:
  - Pass active source.
  - If sel_req != active_src, go to WAIT_OUT and clear the counter.
- WAIT_OUT:
  - Pass active source; counter increments.
  - If sel_req == active_src, cancel and return to RUN; no glitch, output never blanked.
  - On rise of the active source, blank this cycle and go to WAIT_IN.
  - If the new source also rises in that same cycle, go directly to RUN: active_src flips and the new source's signals are loaded that cycle (vsync edge preserved).
  - If counter == TIMEOUT-1, pulse to_pulse, blank, go to WAIT_IN.
- WAIT_IN:
  - Output blanked; sel_req ignored (commit point).
  - On rise of the new source, load the new source this cycle, flip active_src, go to RUN. The first vsync-high cycle is kept.
  - If counter == TIMEOUT-1, pulse to_pulse, flip active_src, go to RUN; output follows the new source raw from the next cycle.
- switching = (state != RUN), registered alongside outputs.
- Counter saturates never; it is cleared on every state entry.
- rst mid-switch: immediate return to reset state with active_src = DEFAULT_SRC. A pending request is re-evaluated from RUN.
- sel_req toggling faster than frames: only the value sampled in RUN/WAIT_OUT matters; no queueing.

Optional Feature:
- Macro VIN_SEL_LOS_EN.
- When defined:
  - Each source has a free-running loss watchdog, cleared on its vsync rise and saturating at TIMEOUT.
  - src_lost[x] = counter_x == TIMEOUT.
  - In RUN, if src_lost[active_src] is set, the output is blanked; it resumes on the next rise of that source.
- When undefined: src_lost tied to 2'b00, no RUN blanking, watchdog logic absent.

Decomposition:
- Package vin_pkg:
  - state enum (RUN, WAIT_OUT, WAIT_IN)
  - SRC_A/SRC_B constants
  - default TIMEOUT/TO_W
- Sub-module vin_vs_mon, instantiated per source:
  - vsync prev register and rise output
  - under VIN_SEL_LOS_EN, the loss watchdog and lost flag

Test Plan:
- Reset with DEFAULT_SRC = 0 -> v_* = 0 and active_src = 0 during rst. First cycle after rst, v_pixel = a_pixel delayed by 1.
- sel_req 0->1 mid-frame of A, B phase-offset by 300 cycles (TIMEOUT = 200 overridden to 1000):
  - A passes until A vsync rise.
  - Blank (v_de = 0, v_pixel = 0) until B rise.
  - v_vsync rises the cycle after B rise; active_src = 1; switching low.
- sel_req 0->1 then back to 0 before A vsync rise -> no blank cycle, switching pulses high then low, active_src stays 0.
- A and B vsync rise in the same cycle while in WAIT_OUT -> zero blank cycles, v_vsync = 1 on the next cycle from B.
- B held idle (vsync = 0) after request, TIMEOUT = 200 -> to_pulse exactly 200 cycles after entering WAIT_IN; active_src = 1, RUN.
- With VIN_SEL_LOS_EN, stop A vsync for 200 cycles while in RUN on A -> src_lost = 2'b01 and output blanked. Restore A -> src_lost clears and output resumes from the rise.
